// File: rtl/irq_pkg.sv
// Shared constants, arbiter state encoding and debug view for the interrupt controller.
package irq_pkg;

    localparam logic [7:0] OFS_MASK   = 8'd0;
    localparam logic [7:0] OFS_PEND   = 8'd1;
    localparam logic [7:0] OFS_MISSED = 8'd2;
    localparam logic [7:0] MISSED_MAX = 8'hFF;

    // Wide enough to name any of up to 8 sources.
    localparam int IDX_W = 3;

    typedef enum logic {
        IRQ_IDLE,
        IRQ_RAISED
    } irq_state_e;

    typedef struct packed {
        irq_state_e             state;
        logic [IDX_W-1:0]       idx;
    } irq_dbg_t;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [7:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Processor-side bus address/strobe and the raise/acknowledge interrupt lines.
interface irq_controller_if #(
    parameter int NUM_IRQ = 2
);
    // Handshake: RAISE is a registered level with at most one bit set; the
    // processor answers with a one-cycle ACK on that same bit, after which the
    // controller drops RAISE and holds it low for at least one cycle.
    logic [7:0]         BUS_ADDR;
    logic               BUS_WE;
    logic [NUM_IRQ-1:0] BUS_INTERRUPTS_RAISE;
    logic [NUM_IRQ-1:0] BUS_INTERRUPTS_ACK;

    modport master (
        output BUS_ADDR,
        output BUS_WE,
        output BUS_INTERRUPTS_ACK,
        input  BUS_INTERRUPTS_RAISE
    );

    modport slave (
        input  BUS_ADDR,
        input  BUS_WE,
        input  BUS_INTERRUPTS_ACK,
        output BUS_INTERRUPTS_RAISE
    );

endinterface

// File: rtl/irq_source_slice.sv
// One interrupt source: registered edge detect, pending flag and saturating lost-event counter.
module irq_source_slice
    import irq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       src_i,
    input  logic       ack_i,
    input  logic       w1c_i,
    input  logic       missed_clr_i,
    output logic       pending_o,
    output logic [7:0] missed_o
);

    logic       src_q;
    logic       evt_q;
    logic       pending_q, pending_d;
    logic [7:0] missed_q, missed_d;
    logic       clear;

    always_comb begin
        clear     = ack_i | w1c_i;
        pending_d = pending_q;
        missed_d  = missed_q;
        // A fresh event outranks any same-cycle clear.
        if (evt_q) begin
            pending_d = 1'b1;
        end else if (clear) begin
            pending_d = 1'b0;
        end
        if (missed_clr_i) begin
            missed_d = '0;
        end else if (evt_q && pending_q && !clear && (missed_q != MISSED_MAX)) begin
            missed_d = missed_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q     <= 1'b0;
            evt_q     <= 1'b0;
            pending_q <= 1'b0;
            missed_q  <= '0;
        end else begin
            src_q     <= src_i;
            evt_q     <= src_i & ~src_q;
            pending_q <= pending_d;
            missed_q  <= missed_d;
        end
    end

    assign pending_o = pending_q;
    assign missed_o  = missed_q;

endmodule

// File: rtl/irq_controller.sv
// Bus-mapped interrupt controller: mask register, fixed-priority single-outstanding
// arbiter and registered tri-state read port over per-source slices.
module irq_controller
    import irq_pkg::*;
#(
    parameter logic [7:0]         BASE_ADDR  = 8'hE0,
    parameter int                 NUM_IRQ    = 2,
    parameter logic [NUM_IRQ-1:0] MASK_RESET = '1
) (
    input  logic               CLK,
    input  logic               RESET,
    inout  wire  [7:0]         BUS_DATA,
    input  logic [NUM_IRQ-1:0] IRQ_SRC,
    irq_controller_if.slave    bus,
    output irq_dbg_t           dbg_o
);

    logic [7:0]         wdata;
    logic               unused_wdata;
    logic [7:0]         ofs;
    logic               hit, wr, rd;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] pending;
    logic [7:0]         missed [NUM_IRQ];
    logic [NUM_IRQ-1:0] w1c, missed_clr, ack_eff;
    logic [NUM_IRQ-1:0] active, lowest;
    logic [NUM_IRQ-1:0] raise_q, raise_d;
    irq_state_e         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               oe_q;

    assign wdata        = BUS_DATA;
    assign unused_wdata = ^wdata;

    // Offset arithmetic wraps mod 256, so one compare covers the whole window.
    assign ofs = bus.BUS_ADDR - BASE_ADDR;
    assign hit = ofs < 8'(2 + NUM_IRQ);
    assign wr  = hit & bus.BUS_WE;
    assign rd  = hit & ~bus.BUS_WE;

    assign w1c     = (wr && ofs == OFS_PEND) ? wdata[NUM_IRQ-1:0] : '0;
    assign ack_eff = raise_q & bus.BUS_INTERRUPTS_ACK;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_src
        assign missed_clr[g] = wr && (ofs == OFS_MISSED + 8'(g));

        irq_source_slice u_slice (
            .clk          (CLK),
            .rst          (RESET),
            .src_i        (IRQ_SRC[g]),
            .ack_i        (ack_eff[g]),
            .w1c_i        (w1c[g]),
            .missed_clr_i (missed_clr[g]),
            .pending_o    (pending[g]),
            .missed_o     (missed[g])
        );
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mask_q <= MASK_RESET;
        end else if (wr && ofs == OFS_MASK) begin
            mask_q <= wdata[NUM_IRQ-1:0];
        end
    end

    assign active = pending & mask_q;
    assign lowest = active & (~active + NUM_IRQ'(1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        raise_d = raise_q;
        case (state_q)
            IRQ_IDLE: begin
                if (|active) begin
                    state_d = IRQ_RAISED;
                    idx_d   = lowest_set(8'(active));
                    raise_d = lowest;
                end
            end
            IRQ_RAISED: begin
                // Leave on acknowledge, or when the raised line lost its mask or pending bit.
                if ((|ack_eff) || !(|(raise_q & active))) begin
                    state_d = IRQ_IDLE;
                    raise_d = '0;
                end
            end
            default: begin
                state_d = IRQ_IDLE;
                raise_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IRQ_IDLE;
            idx_q   <= '0;
            raise_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            raise_q <= raise_d;
        end
    end

    assign bus.BUS_INTERRUPTS_RAISE = raise_q;

    always_comb begin
        dbg_o.state = state_q;
        dbg_o.idx   = idx_q;
    end

    // Read data is taken from current register state, i.e. before this edge's updates.
    always_comb begin
        rdata_d = '0;
        if (ofs == OFS_MASK) begin
            rdata_d[NUM_IRQ-1:0] = mask_q;
        end else if (ofs == OFS_PEND) begin
            rdata_d[NUM_IRQ-1:0] = pending;
        end else begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (ofs == OFS_MISSED + 8'(i)) rdata_d = missed[i];
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            oe_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            oe_q <= rd;
            if (rd) rdata_q <= rdata_d;
        end
    end

    assign BUS_DATA = oe_q ? rdata_q : 8'bz;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios plus random traffic against a cycle model.
module tb_irq_controller;
    import irq_pkg::*;

    localparam int         NUM_IRQ = 2;
    localparam logic [7:0] BASE    = 8'hE0;

    logic               CLK = 1'b0;
    logic               RESET;
    wire  [7:0]         BUS_DATA;
    logic [7:0]         tb_wdata;
    logic               tb_drv;
    logic [NUM_IRQ-1:0] IRQ_SRC;
    irq_dbg_t           dbg;

    irq_controller_if #(.NUM_IRQ(NUM_IRQ)) bus_if ();

    assign BUS_DATA = tb_drv ? tb_wdata : 8'bz;

    irq_controller #(
        .BASE_ADDR  (BASE),
        .NUM_IRQ    (NUM_IRQ),
        .MASK_RESET (2'b11)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .BUS_DATA (BUS_DATA),
        .IRQ_SRC  (IRQ_SRC),
        .bus      (bus_if),
        .dbg_o    (dbg)
    );

    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;
    bit checking    = 1'b0;

    // ---------------- scoreboard / reference model ----------------
    logic [7:0] exp_q[$];
    int m_src    [NUM_IRQ];
    int m_evt    [NUM_IRQ];
    int m_pend   [NUM_IRQ];
    int m_missed [NUM_IRQ];
    int m_mask   [NUM_IRQ];
    int m_raised;

    function automatic void check(string name, logic [7:0] act, logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NUM_IRQ; i++) begin
            m_src[i] = 0; m_evt[i] = 0; m_pend[i] = 0; m_missed[i] = 0; m_mask[i] = 1;
        end
        m_raised = -1;
        exp_q.delete();
    endfunction

    function automatic logic [7:0] model_reg(int ofs);
        logic [7:0] v;
        v = '0;
        if (ofs == 0) begin
            for (int i = 0; i < NUM_IRQ; i++) v[i] = (m_mask[i] != 0);
        end else if (ofs == 1) begin
            for (int i = 0; i < NUM_IRQ; i++) v[i] = (m_pend[i] != 0);
        end else begin
            v = 8'(m_missed[ofs - 2]);
        end
        return v;
    endfunction

    function automatic logic [7:0] model_raise();
        return (m_raised >= 0) ? (8'd1 << m_raised) : 8'd0;
    endfunction

    function automatic void model_step();
        int ofs, n_pend [NUM_IRQ], n_missed [NUM_IRQ], n_evt [NUM_IRQ];
        bit hit, wr, rd, ack, w1c, clr;
        logic [7:0] wd;
        ofs = int'(bus_if.BUS_ADDR) - int'(BASE);
        hit = (ofs >= 0) && (ofs < 2 + NUM_IRQ);
        wr  = hit && bus_if.BUS_WE;
        rd  = hit && !bus_if.BUS_WE;
        wd  = BUS_DATA;
        if (rd) exp_q.push_back(model_reg(ofs));
        for (int i = 0; i < NUM_IRQ; i++) begin
            ack = (m_raised == i) && bus_if.BUS_INTERRUPTS_ACK[i];
            w1c = wr && (ofs == 1) && wd[i];
            clr = ack || w1c;
            n_pend[i]   = (m_evt[i] != 0) ? 1 : (clr ? 0 : m_pend[i]);
            n_missed[i] = m_missed[i];
            if (wr && ofs == 2 + i) n_missed[i] = 0;
            else if (m_evt[i] != 0 && m_pend[i] != 0 && !clr && m_missed[i] < 255)
                n_missed[i] = m_missed[i] + 1;
            n_evt[i] = (IRQ_SRC[i] && m_src[i] == 0) ? 1 : 0;
            m_src[i] = IRQ_SRC[i] ? 1 : 0;
        end
        if (m_raised >= 0) begin
            if (bus_if.BUS_INTERRUPTS_ACK[m_raised] || m_mask[m_raised] == 0 || m_pend[m_raised] == 0)
                m_raised = -1;
        end else begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (m_pend[i] != 0 && m_mask[i] != 0) begin
                    m_raised = i;
                    break;
                end
            end
        end
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (wr && ofs == 0) m_mask[i] = wd[i] ? 1 : 0;
            m_pend[i]   = n_pend[i];
            m_missed[i] = n_missed[i];
            m_evt[i]    = n_evt[i];
        end
    endfunction

    always @(posedge CLK or posedge RESET) begin
        if (RESET) model_reset();
        else model_step();
    end

    // Compare process: raise lines every cycle, read data on every read-return cycle.
    always @(negedge CLK) begin
        if (checking && !RESET) begin
            check("raise", 8'(bus_if.BUS_INTERRUPTS_RAISE), model_raise());
            if (exp_q.size() > 0) check("read_data", BUS_DATA, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(int n = 1);
        repeat (n) @(negedge CLK);
    endtask

    task automatic bus_idle();
        bus_if.BUS_ADDR = 8'h00;
        bus_if.BUS_WE   = 1'b0;
        tb_drv          = 1'b0;
    endtask

    task automatic bus_write(logic [7:0] addr, logic [7:0] data);
        bus_if.BUS_ADDR = addr;
        bus_if.BUS_WE   = 1'b1;
        tb_wdata        = data;
        tb_drv          = 1'b1;
        step();
        bus_idle();
    endtask

    task automatic bus_read_chk(logic [7:0] addr, logic [7:0] exp, string name);
        bus_if.BUS_ADDR = addr;
        bus_if.BUS_WE   = 1'b0;
        step();
        bus_idle();
        check(name, BUS_DATA, exp);
        step();
    endtask

    task automatic pulse(logic [NUM_IRQ-1:0] v);
        IRQ_SRC = v;
        step();
        IRQ_SRC = '0;
    endtask

    task automatic ack(logic [NUM_IRQ-1:0] v);
        bus_if.BUS_INTERRUPTS_ACK = v;
        step();
        bus_if.BUS_INTERRUPTS_ACK = '0;
    endtask

    task automatic chk_raise(logic [7:0] exp, string name);
        check(name, 8'(bus_if.BUS_INTERRUPTS_RAISE), exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int op;
        bit prev_read;
        logic [NUM_IRQ-1:0] ack_v;

        RESET = 1'b0;
        IRQ_SRC = '0;
        bus_if.BUS_INTERRUPTS_ACK = '0;
        tb_wdata = '0;
        bus_idle();
        #2 RESET = 1'b1;
        step(3);
        RESET = 1'b0;
        checking = 1'b1;
        step(2);

        // Reset state
        chk_raise(8'h00, "reset_raise");
        check("reset_state", 8'(dbg.state), 8'(IRQ_IDLE));
        bus_read_chk(BASE + 8'd0, 8'h03, "reset_mask");
        bus_read_chk(BASE + 8'd1, 8'h00, "reset_pend");
        bus_read_chk(BASE + 8'd2, 8'h00, "reset_missed0");
        bus_read_chk(BASE + 8'd3, 8'h00, "reset_missed1");

        // Single event on source 0, raise two edges after sampling, then ACK
        pulse(2'b01);
        chk_raise(8'h00, "t1_raise_n");
        step();
        chk_raise(8'h00, "t1_raise_n1");
        step();
        chk_raise(8'h01, "t1_raise_n2");
        step(3);
        ack(2'b01);
        chk_raise(8'h00, "t1_raise_after_ack");
        bus_read_chk(BASE + 8'd1, 8'h00, "t1_pend");

        // Simultaneous events: lower index first, then the other after the gap
        pulse(2'b11);
        step(2);
        chk_raise(8'h01, "t2_first");
        ack(2'b01);
        chk_raise(8'h00, "t2_gap");
        step();
        chk_raise(8'h02, "t2_second");
        ack(2'b10);
        chk_raise(8'h00, "t2_done");
        bus_read_chk(BASE + 8'd1, 8'h00, "t2_pend");

        // Missed-event saturation on masked source 1
        bus_write(BASE + 8'd0, 8'h01);
        pulse(2'b10);
        step();
        for (int i = 0; i < 300; i++) begin
            pulse(2'b10);
            step();
        end
        chk_raise(8'h00, "t3_masked_raise");
        bus_read_chk(BASE + 8'd3, 8'hFF, "t3_missed_sat");
        bus_write(BASE + 8'd3, 8'h5A);
        bus_read_chk(BASE + 8'd3, 8'h00, "t3_missed_clr");
        bus_read_chk(BASE + 8'd1, 8'h02, "t3_pend");
        bus_write(BASE + 8'd1, 8'h02);
        bus_read_chk(BASE + 8'd1, 8'h00, "t3_pend_w1c");

        // Mask gating and W1C withdrawal of a raised line
        bus_write(BASE + 8'd0, 8'h00);
        pulse(2'b01);
        step(3);
        chk_raise(8'h00, "t4_masked");
        bus_read_chk(BASE + 8'd1, 8'h01, "t4_pend");
        bus_write(BASE + 8'd0, 8'h01);
        chk_raise(8'h00, "t4_unmask_w");
        step();
        chk_raise(8'h01, "t4_unmask_w1");
        bus_write(BASE + 8'd1, 8'h01);
        chk_raise(8'h01, "t4_w1c_w");
        step();
        chk_raise(8'h00, "t4_w1c_w1");
        bus_read_chk(BASE + 8'd1, 8'h00, "t4_pend_clr");
        bus_write(BASE + 8'd0, 8'h03);

        // Event colliding with ACK on the raised line
        pulse(2'b01);
        step(2);
        chk_raise(8'h01, "t5_raised");
        IRQ_SRC = 2'b01;
        step();
        IRQ_SRC = 2'b00;
        ack(2'b01);
        chk_raise(8'h00, "t5_gap");
        step();
        chk_raise(8'h01, "t5_reraise");
        bus_read_chk(BASE + 8'd2, 8'h00, "t5_missed0");
        bus_read_chk(BASE + 8'd1, 8'h01, "t5_pend");
        ack(2'b01);
        bus_read_chk(BASE + 8'd1, 8'h00, "t5_pend_clr");

        // Asynchronous reset while source 1 is raised
        bus_write(BASE + 8'd0, 8'h02);
        pulse(2'b01);
        pulse(2'b10);
        step(2);
        chk_raise(8'h02, "t6_raised");
        #2 RESET = 1'b1;
        #1 chk_raise(8'h00, "t6_async_raise");
        check("t6_async_state", 8'(dbg.state), 8'(IRQ_IDLE));
        step(2);
        RESET = 1'b0;
        step();
        bus_read_chk(BASE + 8'd0, 8'h03, "t6_mask");
        bus_read_chk(BASE + 8'd1, 8'h00, "t6_pend");
        bus_read_chk(BASE + 8'd2, 8'h00, "t6_missed0");
        bus_read_chk(BASE + 8'd3, 8'h00, "t6_missed1");

        // Random traffic against the model
        prev_read = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NUM_IRQ; i++) IRQ_SRC[i] = ($urandom_range(0, 3) == 0);
            ack_v = '0;
            if (bus_if.BUS_INTERRUPTS_RAISE != '0 && $urandom_range(0, 2) == 0)
                ack_v = bus_if.BUS_INTERRUPTS_RAISE;
            else if ($urandom_range(0, 15) == 0)
                ack_v = NUM_IRQ'($urandom);
            bus_if.BUS_INTERRUPTS_ACK = ack_v;
            bus_idle();
            op = $urandom_range(0, 9);
            if (op < 3) begin
                bus_if.BUS_ADDR = BASE - 8'd1 + 8'($urandom_range(0, 5));
                prev_read = 1'b1;
            end else if (op < 5 && !prev_read) begin
                bus_if.BUS_ADDR = BASE + 8'($urandom_range(0, 3));
                bus_if.BUS_WE   = 1'b1;
                tb_wdata        = 8'($urandom);
                tb_drv          = 1'b1;
            end else begin
                prev_read = 1'b0;
            end
            step();
        end
        IRQ_SRC = '0;
        bus_if.BUS_INTERRUPTS_ACK = '0;
        bus_idle();
        step(5);
        check("read_queue_drained", 8'(exp_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
